// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register and next-PC selection for the five-stage MIPS pipeline,
// with a return-address stack that only observes jr $31 targets and counts mispredictions.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI   = 32'h0000_6ffc,
  parameter int          RAS_DEPTH = 8,
  parameter int          CNT_W     = 16,
  localparam int         PTR_W     = $clog2(RAS_DEPTH),
  localparam int         OCC_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_f,
  input  logic [31:0]       pc_d,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic              is_b,
  input  logic              b_taken,
  input  logic              is_j,
  input  logic              is_jr,
  input  logic              link,
  input  logic [4:0]        rs_idx,
  input  logic [31:0]       rs_val,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [31:0]       epc,
  output logic [31:0]       pc_f,
  output logic [31:0]       pc8_d,
  output logic              adel_f,
  output logic [OCC_W-1:0]  ras_cnt,
  output logic [CNT_W-1:0]  ras_miss_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] off);
    logic signed [31:0] boff;
    boff = {{14{off[15]}}, off, 2'b00};
    return pc + 32'd4 + $unsigned(boff);
  endfunction

  logic [31:0]      pc_f_q, pc_f_d;
  logic [31:0]      ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic             ctl_en;
  logic             jr31;
  logic             do_push, do_pop, do_swap, do_chk;
  logic             ras_empty, ras_full, ras_miss;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_inc, top_dec;

  assign ctl_en  = !stall_f && !exc_req && !eret_req;
  assign pc8_d   = pc_d + 32'd8;
  assign jr31    = is_jr && (rs_idx == 5'd31);

  // Next-PC selection, highest priority first.
  always_comb begin
    pc_f_d = pc_f_q + 32'd4;
    if (exc_req)              pc_f_d = EXC_PC;
    else if (eret_req)        pc_f_d = epc;
    else if (stall_f)         pc_f_d = pc_f_q;
    else if (is_jr)           pc_f_d = rs_val;
    else if (is_j)            pc_f_d = {pc_d[31:28], imm26, 2'b00};
    else if (is_b && b_taken) pc_f_d = branch_target(pc_d, imm16);
  end

  assign do_push   = ctl_en && link && !jr31;
  assign do_pop    = ctl_en && jr31 && !link;
  assign do_swap   = ctl_en && jr31 && link;
  assign do_chk    = do_pop || do_swap;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == OCC_W'(RAS_DEPTH));
  assign ras_miss  = do_chk && (ras_empty || (ras_q[top_q] != rs_val));
  assign top_inc   = top_q + 1'b1;
  assign top_dec   = top_q - 1'b1;

  // A full push wraps onto the oldest slot; jalr $31 on an empty stack behaves as a push.
  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    miss_d = ras_miss ? sat_inc(miss_q) : miss_q;
    if (exc_req) begin
      cnt_d = '0;
    end else if (do_push) begin
      wr_en  = 1'b1;
      wr_idx = top_inc;
      top_d  = top_inc;
      cnt_d  = ras_full ? cnt_q : cnt_q + 1'b1;
    end else if (do_pop) begin
      if (!ras_empty) begin
        top_d = top_dec;
        cnt_d = cnt_q - 1'b1;
      end
    end else if (do_swap) begin
      wr_en = 1'b1;
      if (ras_empty) begin
        wr_idx = top_inc;
        top_d  = top_inc;
        cnt_d  = OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q <= RESET_PC;
      top_q  <= '0;
      cnt_q  <= '0;
      miss_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_f_q <= pc_f_d;
      top_q  <= top_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
      if (wr_en) ras_q[wr_idx] <= pc8_d;
    end
  end

  assign pc_f         = pc_f_q;
  assign ras_cnt      = cnt_q;
  assign ras_miss_cnt = miss_q;
  assign adel_f       = (pc_f_q[1:0] != 2'b00) || (pc_f_q < TEXT_LO) || (pc_f_q > TEXT_HI);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected PCs are queued as stimulus is driven
// and popped after the clock edge that should produce them.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_f;
  logic [31:0] pc_d;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        is_b, b_taken, is_j, is_jr, link;
  logic [4:0]  rs_idx;
  logic [31:0] rs_val;
  logic        exc_req, eret_req;
  logic [31:0] epc;
  logic [31:0] pc_f, pc8_d;
  logic        adel_f;
  logic [3:0]  ras_cnt;
  logic [15:0] ras_miss_cnt;

  logic [31:0] s_pc_f, s_pc8_d;
  logic        s_adel_f;
  logic [3:0]  s_ras_cnt;
  logic [1:0]  s_miss;

  int          total = 0;
  int          bad   = 0;
  int          exp_miss = 0;
  logic [31:0] cur;
  logic [31:0] e;
  logic [31:0] exp_pc_q [$];

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .pc_d(pc_d), .imm16(imm16),
    .imm26(imm26), .is_b(is_b), .b_taken(b_taken), .is_j(is_j), .is_jr(is_jr),
    .link(link), .rs_idx(rs_idx), .rs_val(rs_val), .exc_req(exc_req),
    .eret_req(eret_req), .epc(epc), .pc_f(pc_f), .pc8_d(pc8_d), .adel_f(adel_f),
    .ras_cnt(ras_cnt), .ras_miss_cnt(ras_miss_cnt)
  );

  pc_fetch_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .pc_d(pc_d), .imm16(imm16),
    .imm26(imm26), .is_b(is_b), .b_taken(b_taken), .is_j(is_j), .is_jr(is_jr),
    .link(link), .rs_idx(rs_idx), .rs_val(rs_val), .exc_req(exc_req),
    .eret_req(eret_req), .epc(epc), .pc_f(s_pc_f), .pc8_d(s_pc8_d), .adel_f(s_adel_f),
    .ras_cnt(s_ras_cnt), .ras_miss_cnt(s_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctl();
    stall_f = 0; pc_d = 32'h3000; imm16 = 0; imm26 = 0; is_b = 0; b_taken = 0;
    is_j = 0; is_jr = 0; link = 0; rs_idx = 0; rs_val = 0; exc_req = 0;
    eret_req = 0; epc = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clr_ctl();
    repeat (3) tick();
    total++; if (pc_f !== 32'h3000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_f, 32'h3000); end
    total++; if (ras_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", ras_cnt); end
    total++; if (ras_miss_cnt !== 16'd0) begin bad++; $display("FAIL reset_miss got=%0d exp=0", ras_miss_cnt); end
    total++; if (adel_f !== 1'b0) begin bad++; $display("FAIL reset_adel got=%b exp=0", adel_f); end
    rst_n = 1;
    cur = 32'h3000;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      exp_pc_q.push_back(cur + 32'd4);
      cur = cur + 32'd4;
      tick();
      e = exp_pc_q.pop_front();
      total++; if (pc_f !== e) begin bad++; $display("FAIL seq_pc got=%h exp=%h", pc_f, e); end
      total++; if (adel_f !== 1'b0) begin bad++; $display("FAIL seq_adel got=%b exp=0", adel_f); end
    end
  endtask

  task automatic test_stall();
    stall_f = 1; is_j = 1; imm26 = 26'h0000c40; pc_d = 32'h3010; link = 1;
    for (int i = 0; i < 2; i++) begin
      exp_pc_q.push_back(cur);
      tick();
      e = exp_pc_q.pop_front();
      total++; if (pc_f !== e) begin bad++; $display("FAIL stall_hold got=%h exp=%h", pc_f, e); end
    end
    total++; if (ras_cnt !== 4'd0) begin bad++; $display("FAIL stall_ras got=%0d exp=0", ras_cnt); end
    clr_ctl();
    exp_pc_q.push_back(cur + 32'd4);
    cur = cur + 32'd4;
    tick();
    e = exp_pc_q.pop_front();
    total++; if (pc_f !== e) begin bad++; $display("FAIL stall_release got=%h exp=%h", pc_f, e); end
  endtask

  task automatic test_branch();
    logic [31:0] pcd_t [3] = '{32'h3010, 32'h3010, 32'h3008};
    logic [15:0] imm_t [3] = '{16'hfffc, 16'hfffc, 16'h0010};
    logic        tk_t  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] exp_t [3] = '{32'h3004, 32'h3008, 32'h304c};
    for (int i = 0; i < 3; i++) begin
      is_b = 1; b_taken = tk_t[i]; pc_d = pcd_t[i]; imm16 = imm_t[i];
      #1;
      total++; if (pc8_d !== pcd_t[i] + 32'd8) begin bad++; $display("FAIL pc8_d got=%h exp=%h", pc8_d, pcd_t[i] + 32'd8); end
      exp_pc_q.push_back(exp_t[i]);
      tick();
      e = exp_pc_q.pop_front();
      total++; if (pc_f !== e) begin bad++; $display("FAIL branch_pc%0d got=%h exp=%h", i, pc_f, e); end
    end
    clr_ctl();
    cur = 32'h304c;
  endtask

  task automatic test_jump();
    is_j = 1; pc_d = 32'h3050; imm26 = 26'h0000c40;
    exp_pc_q.push_back(32'h3100);
    tick();
    e = exp_pc_q.pop_front();
    total++; if (pc_f !== e) begin bad++; $display("FAIL j_pc got=%h exp=%h", pc_f, e); end
    pc_d = 32'ha000_3050;
    exp_pc_q.push_back(32'ha000_3100);
    tick();
    e = exp_pc_q.pop_front();
    total++; if (pc_f !== e) begin bad++; $display("FAIL j_region got=%h exp=%h", pc_f, e); end
    total++; if (adel_f !== 1'b1) begin bad++; $display("FAIL adel_high got=%b exp=1", adel_f); end
    is_jr = 1; rs_idx = 5; rs_val = 32'h3200;
    exp_pc_q.push_back(32'h3200);
    tick();
    e = exp_pc_q.pop_front();
    total++; if (pc_f !== e) begin bad++; $display("FAIL jr_prio got=%h exp=%h", pc_f, e); end
    clr_ctl();
    cur = 32'h3200;
  endtask

  task automatic test_ras_basic();
    logic [31:0] rv_t [2] = '{32'h3028, 32'h3030};
    for (int i = 0; i < 2; i++) begin
      is_j = 1; link = 1; pc_d = 32'h3020; imm26 = 26'h0000c40;
      exp_pc_q.push_back(32'h3100);
      tick();
      e = exp_pc_q.pop_front();
      total++; if (pc_f !== e) begin bad++; $display("FAIL jal_pc got=%h exp=%h", pc_f, e); end
      total++; if (ras_cnt !== 4'd1) begin bad++; $display("FAIL jal_cnt got=%0d exp=1", ras_cnt); end
      clr_ctl();
      is_jr = 1; rs_idx = 31; rs_val = rv_t[i];
      if (i == 1) exp_miss++;
      exp_pc_q.push_back(rv_t[i]);
      tick();
      e = exp_pc_q.pop_front();
      total++; if (pc_f !== e) begin bad++; $display("FAIL ret_pc got=%h exp=%h", pc_f, e); end
      total++; if (ras_miss_cnt !== 16'(exp_miss)) begin bad++; $display("FAIL ret_miss got=%0d exp=%0d", ras_miss_cnt, exp_miss); end
      total++; if (ras_cnt !== 4'd0) begin bad++; $display("FAIL ret_cnt got=%0d exp=0", ras_cnt); end
      clr_ctl();
    end
    cur = 32'h3030;
  endtask

  task automatic test_ras_depth();
    for (int k = 0; k <= 8; k++) begin
      link = 1; pc_d = 32'h3000 + 32'(16 * k);
      exp_pc_q.push_back(cur + 32'd4);
      cur = cur + 32'd4;
      tick();
      e = exp_pc_q.pop_front();
      total++; if (pc_f !== e) begin bad++; $display("FAIL push_pc got=%h exp=%h", pc_f, e); end
      total++; if (ras_cnt !== 4'((k + 1 > 8) ? 8 : k + 1)) begin bad++; $display("FAIL push_cnt k=%0d got=%0d", k, ras_cnt); end
    end
    clr_ctl();
    for (int j = 0; j <= 8; j++) begin
      is_jr = 1; rs_idx = 31; rs_val = 32'h3008 + 32'(16 * (8 - j));
      if (j == 8) exp_miss++;
      exp_pc_q.push_back(rs_val);
      cur = rs_val;
      tick();
      e = exp_pc_q.pop_front();
      total++; if (pc_f !== e) begin bad++; $display("FAIL pop_pc got=%h exp=%h", pc_f, e); end
      total++; if (ras_cnt !== 4'((7 - j < 0) ? 0 : 7 - j)) begin bad++; $display("FAIL pop_cnt j=%0d got=%0d", j, ras_cnt); end
      total++; if (ras_miss_cnt !== 16'(exp_miss)) begin bad++; $display("FAIL pop_miss j=%0d got=%0d exp=%0d", j, ras_miss_cnt, exp_miss); end
    end
    clr_ctl();
  endtask

  task automatic test_jalr();
    logic        jr_t  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        lk_t  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0]  rs_t  [7] = '{5'd0, 5'd31, 5'd31, 5'd31, 5'd4, 5'd31, 5'd31};
    logic [31:0] rv_t  [7] = '{32'h0, 32'h3108, 32'h3208, 32'h3300, 32'h3400, 32'h3408, 32'h3308};
    logic [31:0] pd_t  [7] = '{32'h3100, 32'h3200, 32'h3000, 32'h3300, 32'h3400, 32'h3000, 32'h3000};
    int          cn_t  [7] = '{1, 1, 0, 1, 2, 1, 0};
    int          ms_t  [7] = '{0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      is_jr = jr_t[i]; link = lk_t[i]; rs_idx = rs_t[i]; rs_val = rv_t[i]; pc_d = pd_t[i];
      cur = jr_t[i] ? rv_t[i] : cur + 32'd4;
      exp_miss += ms_t[i];
      exp_pc_q.push_back(cur);
      tick();
      e = exp_pc_q.pop_front();
      total++; if (pc_f !== e) begin bad++; $display("FAIL jalr_pc%0d got=%h exp=%h", i, pc_f, e); end
      total++; if (ras_cnt !== 4'(cn_t[i])) begin bad++; $display("FAIL jalr_cnt%0d got=%0d exp=%0d", i, ras_cnt, cn_t[i]); end
      total++; if (ras_miss_cnt !== 16'(exp_miss)) begin bad++; $display("FAIL jalr_miss%0d got=%0d exp=%0d", i, ras_miss_cnt, exp_miss); end
    end
    clr_ctl();
  endtask

  task automatic test_exc_eret();
    logic [31:0] ep_t [4] = '{32'h7000, 32'h6ffc, 32'h2ffc, 32'h3000};
    logic        ad_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    link = 1; pc_d = 32'h3500;
    exp_pc_q.push_back(cur + 32'd4);
    tick();
    e = exp_pc_q.pop_front();
    total++; if (ras_cnt !== 4'd1) begin bad++; $display("FAIL pre_exc_cnt got=%0d exp=1", ras_cnt); end
    stall_f = 1; exc_req = 1;
    exp_pc_q.push_back(32'h4180);
    tick();
    e = exp_pc_q.pop_front();
    total++; if (pc_f !== e) begin bad++; $display("FAIL exc_pc got=%h exp=%h", pc_f, e); end
    total++; if (ras_cnt !== 4'd0) begin bad++; $display("FAIL exc_cnt got=%0d exp=0", ras_cnt); end
    total++; if (ras_miss_cnt !== 16'(exp_miss)) begin bad++; $display("FAIL exc_miss got=%0d exp=%0d", ras_miss_cnt, exp_miss); end
    total++; if (adel_f !== 1'b0) begin bad++; $display("FAIL exc_adel got=%b exp=0", adel_f); end
    clr_ctl();
    eret_req = 1; epc = 32'h3002; is_j = 1;
    exp_pc_q.push_back(32'h3002);
    tick();
    e = exp_pc_q.pop_front();
    total++; if (pc_f !== e) begin bad++; $display("FAIL eret_pc got=%h exp=%h", pc_f, e); end
    total++; if (adel_f !== 1'b1) begin bad++; $display("FAIL eret_adel got=%b exp=1", adel_f); end
    clr_ctl();
    link = 1; pc_d = 32'h3600;
    tick();
    exc_req = 1; eret_req = 1; epc = 32'h3400;
    exp_pc_q.push_back(32'h4180);
    tick();
    e = exp_pc_q.pop_front();
    total++; if (pc_f !== e) begin bad++; $display("FAIL exc_eret_pc got=%h exp=%h", pc_f, e); end
    total++; if (ras_cnt !== 4'd0) begin bad++; $display("FAIL exc_eret_cnt got=%0d exp=0", ras_cnt); end
    clr_ctl();
    for (int i = 0; i < 4; i++) begin
      eret_req = 1; epc = ep_t[i];
      exp_pc_q.push_back(ep_t[i]);
      tick();
      e = exp_pc_q.pop_front();
      total++; if (pc_f !== e) begin bad++; $display("FAIL eret_bound_pc got=%h exp=%h", pc_f, e); end
      total++; if (adel_f !== ad_t[i]) begin bad++; $display("FAIL adel_bound pc=%h got=%b exp=%b", pc_f, adel_f, ad_t[i]); end
    end
    clr_ctl();
  endtask

  task automatic test_saturation();
    is_jr = 1; rs_idx = 31; rs_val = 32'h3000;
    exp_miss++;
    exp_pc_q.push_back(32'h3000);
    tick();
    e = exp_pc_q.pop_front();
    total++; if (pc_f !== e) begin bad++; $display("FAIL sat_pc got=%h exp=%h", pc_f, e); end
    total++; if (ras_miss_cnt !== 16'(exp_miss)) begin bad++; $display("FAIL sat_miss_main got=%0d exp=%0d", ras_miss_cnt, exp_miss); end
    total++; if (s_miss !== 2'((exp_miss > 3) ? 3 : exp_miss)) begin bad++; $display("FAIL sat_miss_narrow got=%0d exp=%0d", s_miss, (exp_miss > 3) ? 3 : exp_miss); end
    clr_ctl();
  endtask

  task automatic test_async_reset();
    tick();
    #2;
    rst_n = 0;
    #1;
    total++; if (pc_f !== 32'h3000) begin bad++; $display("FAIL async_pc got=%h exp=%h", pc_f, 32'h3000); end
    total++; if (ras_miss_cnt !== 16'd0) begin bad++; $display("FAIL async_miss got=%0d exp=0", ras_miss_cnt); end
    total++; if (ras_cnt !== 4'd0) begin bad++; $display("FAIL async_cnt got=%0d exp=0", ras_cnt); end
    tick();
    rst_n = 1;
    exp_pc_q.push_back(32'h3004);
    tick();
    e = exp_pc_q.pop_front();
    total++; if (pc_f !== e) begin bad++; $display("FAIL post_reset_pc got=%h exp=%h", pc_f, e); end
  endtask

  initial begin
    test_reset();
    total++; if (pc_f !== 32'h3000) begin bad++; $display("FAIL release_pc got=%h exp=%h", pc_f, 32'h3000); end
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_ras_basic();
    test_ras_depth();
    test_jalr();
    test_exc_eret();
    test_saturation();
    test_async_reset();
    total++; if (exp_pc_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_pc_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
